// File: rtl/nois_system_nios2_gen2_0_cpu_debug_mem_engine_if.sv
// Simple word-addressed memory request port between the debug memory engine
// (master) and the memory/interconnect it drives (slave).
interface nois_system_nios2_gen2_0_cpu_debug_mem_engine_if #(
  parameter int ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_address;
  logic              mem_read;
  logic              mem_write;
  logic [31:0]       mem_writedata;
  logic              mem_waitrequest;
  logic [31:0]       mem_readdata;
  logic              mem_readdatavalid;

  modport master (
    output mem_address, mem_read, mem_write, mem_writedata,
    input  mem_waitrequest, mem_readdata, mem_readdatavalid
  );

  modport slave (
    input  mem_address, mem_read, mem_write, mem_writedata,
    output mem_waitrequest, mem_readdata, mem_readdatavalid
  );
endinterface

// File: rtl/nois_system_nios2_gen2_0_cpu_debug_mem_engine.sv
// Debug memory access engine: turns decoded JTAG ocimem strobes into single-word
// reads/writes with auto-incrementing address and a timeout on every access.
module nois_system_nios2_gen2_0_cpu_debug_mem_engine #(
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [37:0] jdo,
  input  logic        take_action_ocimem_a,
  input  logic        take_no_action_ocimem_a,
  input  logic        take_action_ocimem_b,
  nois_system_nios2_gen2_0_cpu_debug_mem_engine_if.master mem,
  output logic [31:0] MonDReg,
  output logic        monitor_ready,
  output logic        monitor_error,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WR_REQ, RD_REQ, RD_WAIT} state_t;

  localparam logic [15:0] TIMEOUT_L = 16'(TIMEOUT);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [31:0]       wdata_reg, wdata_next;
  logic [31:0]       mon_reg, mon_next;
  logic              ready_reg, ready_next;
  logic              error_reg, error_next;
  logic              drop_reg, drop_next;
  logic              busy_reg;
  logic [15:0]       cnt_reg, cnt_next, cnt_inc;
  logic              strobe_any;
  logic              done;
  logic              unused_jdo;

  assign unused_jdo = ^{jdo[37:35], jdo[1:0]};
  assign strobe_any = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
  assign cnt_inc    = cnt_reg + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
      mon_reg   <= '0;
      ready_reg <= 1'b0;
      error_reg <= 1'b0;
      drop_reg  <= 1'b0;
      cnt_reg   <= '0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      mon_reg   <= mon_next;
      ready_reg <= ready_next;
      error_reg <= error_next;
      drop_reg  <= drop_next;
      cnt_reg   <= cnt_next;
      busy_reg  <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next = state_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    mon_next   = mon_reg;
    ready_next = ready_reg;
    error_next = error_reg;
    drop_next  = drop_reg;
    cnt_next   = cnt_reg;
    done       = 1'b0;

    if (state_reg == IDLE) begin
      // Priority b > a > no_action_a; a losing strobe is remembered as a drop.
      if (take_action_ocimem_b) begin
        state_next = WR_REQ;
        wdata_next = jdo[34:3];
        mon_next   = jdo[34:3];
        ready_next = 1'b0;
        error_next = 1'b0;
        drop_next  = take_action_ocimem_a | take_no_action_ocimem_a;
        cnt_next   = '0;
      end else if (take_action_ocimem_a) begin
        addr_next  = jdo[ADDR_W+1:2];
        drop_next  = take_no_action_ocimem_a;
        cnt_next   = '0;
        if (jdo[34]) begin
          state_next = RD_REQ;
          ready_next = 1'b0;
          error_next = 1'b0;
        end else begin
          ready_next = 1'b1;
          error_next = take_no_action_ocimem_a;
        end
      end else if (take_no_action_ocimem_a) begin
        state_next = RD_REQ;
        ready_next = 1'b0;
        error_next = 1'b0;
        drop_next  = 1'b0;
        cnt_next   = '0;
      end
    end else begin
      cnt_next = cnt_inc;
      if (strobe_any) begin
        drop_next = 1'b1;
      end
      case (state_reg)
        WR_REQ: begin
          if (!mem.mem_waitrequest) begin
            done      = 1'b1;
            addr_next = addr_reg + ADDR_W'(1);
          end
        end
        RD_REQ: begin
          if (!mem.mem_waitrequest) begin
            if (mem.mem_readdatavalid) begin
              done      = 1'b1;
              mon_next  = mem.mem_readdata;
              addr_next = addr_reg + ADDR_W'(1);
            end else begin
              state_next = RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          if (mem.mem_readdatavalid) begin
            done      = 1'b1;
            mon_next  = mem.mem_readdata;
            addr_next = addr_reg + ADDR_W'(1);
          end
        end
        default: ;
      endcase
      // A completing cycle wins over a coincident timeout.
      if (done) begin
        state_next = IDLE;
        ready_next = 1'b1;
        error_next = drop_reg | strobe_any;
      end else if (cnt_inc >= TIMEOUT_L) begin
        state_next = IDLE;
        addr_next  = addr_reg;
        ready_next = 1'b1;
        error_next = 1'b1;
      end
    end
  end

  assign mem.mem_address   = addr_reg;
  assign mem.mem_read      = (state_reg == RD_REQ);
  assign mem.mem_write     = (state_reg == WR_REQ);
  assign mem.mem_writedata = wdata_reg;
  assign MonDReg           = mon_reg;
  assign monitor_ready     = ready_reg;
  assign monitor_error     = error_reg;
  assign busy              = busy_reg;

endmodule

// File: tb/tb_nois_system_nios2_gen2_0_cpu_debug_mem_engine.sv
// Bench for the debug memory engine: directed and randomized ocimem commands
// checked against a cycle-count/outcome model derived from the command rules.
module tb_nois_system_nios2_gen2_0_cpu_debug_mem_engine;
  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [37:0] jdo = '0;
  logic        take_action_ocimem_a = 1'b0;
  logic        take_no_action_ocimem_a = 1'b0;
  logic        take_action_ocimem_b = 1'b0;
  logic [31:0] MonDReg;
  logic        monitor_ready, monitor_error, busy;

  nois_system_nios2_gen2_0_cpu_debug_mem_engine_if #(.ADDR_W(ADDR_W)) mem_if ();

  nois_system_nios2_gen2_0_cpu_debug_mem_engine #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk                     (clk),
    .reset                   (reset),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .mem                     (mem_if),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error),
    .busy                    (busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  logic [ADDR_W-1:0] exp_addr  = '0;
  logic [31:0]       exp_mon   = '0;
  logic [31:0]       exp_wdata = '0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] mk_a(input logic rd, input logic [ADDR_W-1:0] a);
    logic [37:0] j;
    j = {$urandom, $urandom};
    j[ADDR_W+1:2] = a;
    j[34] = rd;
    return j;
  endfunction

  function automatic logic [37:0] mk_b(input logic [31:0] d);
    logic [37:0] j;
    j = {$urandom, $urandom};
    j[34:3] = d;
    return j;
  endfunction

  // wait_n: cycles of waitrequest high before acceptance; lat: cycles from
  // acceptance to readdatavalid (0 = same cycle); inject_k: busy cycle index
  // in which a stray no_action strobe is pulsed (0 = none).
  task automatic do_cmd(input logic sb, input logic sa, input logic sn, input logic [37:0] j,
                        input int wait_n, input int lat, input logic [31:0] rdata,
                        input int inject_k, input string tag);
    logic is_wr, is_rd, immediate, collision, timed, injected, bad_addr, bad_wdata, fin;
    logic exp_err;
    int c, exp_k, exp_req, k, rd_cyc, wr_cyc;
    logic [ADDR_W-1:0] req_addr;

    is_wr     = sb;
    is_rd     = !sb && (sa ? j[34] : sn);
    immediate = !sb && sa && !j[34];
    collision = sb ? (sa | sn) : (sa & sn);
    if (!sb && sa) exp_addr = j[ADDR_W+1:2];
    req_addr = exp_addr;
    if (sb) begin
      exp_mon   = j[34:3];
      exp_wdata = j[34:3];
    end
    timed = 1'b0;
    injected = 1'b0;
    if (immediate) begin
      exp_k = 1;
      exp_req = 0;
    end else begin
      c = is_wr ? wait_n + 1 : wait_n + 1 + lat;
      timed = (c > TIMEOUT);
      exp_k = (timed ? TIMEOUT : c) + 1;
      exp_req = (wait_n + 1 > TIMEOUT) ? TIMEOUT : wait_n + 1;
      injected = (inject_k >= 1) && (inject_k < exp_k);
    end
    exp_err = collision | injected | timed;
    if (!immediate && !timed) begin
      exp_addr = exp_addr + 1'b1;
      if (is_rd) exp_mon = rdata;
    end

    @(negedge clk);
    jdo = j;
    take_action_ocimem_b = sb;
    take_action_ocimem_a = sa;
    take_no_action_ocimem_a = sn;
    mem_if.mem_waitrequest = 1'b0;
    mem_if.mem_readdatavalid = 1'b0;
    k = 0; rd_cyc = 0; wr_cyc = 0; bad_addr = 0; bad_wdata = 0; fin = 0;
    while (!fin && k < 200) begin
      @(negedge clk);
      k++;
      take_action_ocimem_a = 1'b0;
      take_no_action_ocimem_a = 1'b0;
      take_action_ocimem_b = 1'b0;
      mem_if.mem_readdatavalid = 1'b0;
      if (!busy) begin
        fin = 1;
      end else begin
        if (mem_if.mem_read) begin
          rd_cyc++;
          if (mem_if.mem_address !== req_addr) bad_addr = 1;
        end
        if (mem_if.mem_write) begin
          wr_cyc++;
          if (mem_if.mem_address !== req_addr) bad_addr = 1;
          if (mem_if.mem_writedata !== exp_wdata) bad_wdata = 1;
        end
        mem_if.mem_waitrequest = (k <= wait_n);
        mem_if.mem_readdatavalid = (k == wait_n + 1 + lat);
        mem_if.mem_readdata = (k == wait_n + 1 + lat) ? rdata : $urandom;
        if (k == inject_k) take_no_action_ocimem_a = 1'b1;
      end
    end
    mem_if.mem_waitrequest = 1'b0;

    check({tag, "_cycles"}, k, exp_k);
    check({tag, "_ready"}, monitor_ready, 1'b1);
    check({tag, "_error"}, monitor_error, exp_err);
    check({tag, "_mondreg"}, MonDReg, exp_mon);
    check({tag, "_addr"}, mem_if.mem_address, exp_addr);
    check({tag, "_rd_cycles"}, rd_cyc, is_rd ? exp_req : 0);
    check({tag, "_wr_cycles"}, wr_cyc, is_wr ? exp_req : 0);
    check({tag, "_req_addr_stable"}, bad_addr, 1'b0);
    check({tag, "_wdata_stable"}, bad_wdata, 1'b0);
    check({tag, "_wdata"}, mem_if.mem_writedata, exp_wdata);
    $display("txn %s cycles=%0d addr=%h mon=%h ready=%b error=%b",
             tag, k, mem_if.mem_address, MonDReg, monitor_ready, monitor_error);
  endtask

  initial begin
    mem_if.mem_waitrequest = 1'b0;
    mem_if.mem_readdata = '0;
    mem_if.mem_readdatavalid = 1'b0;

    @(negedge clk);
    check("reset_mondreg", MonDReg, 32'h0);
    check("reset_ready", monitor_ready, 1'b0);
    check("reset_error", monitor_error, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_rd_wr", {mem_if.mem_read, mem_if.mem_write}, 2'b00);
    check("reset_addr", mem_if.mem_address, '0);
    reset = 1'b0;

    do_cmd(0, 1, 0, mk_a(1'b0, 8'h10), 0, 0, 0, 0, "load_addr_10");
    do_cmd(1, 0, 0, mk_b(32'hDEADBEEF), 0, 0, 0, 0, "write_deadbeef");
    do_cmd(0, 1, 0, mk_a(1'b1, 8'h20), 3, 2, 32'h12345678, 0, "read_wait_states");
    do_cmd(0, 1, 0, mk_a(1'b0, 8'hFF), 0, 0, 0, 0, "load_addr_ff");
    do_cmd(0, 0, 1, mk_a(1'b0, 8'h00), 0, 1, $urandom, 0, "read_wrap");
    do_cmd(1, 0, 0, mk_b($urandom), 100, 0, 0, 0, "write_timeout");
    do_cmd(0, 1, 0, mk_a(1'b0, 8'h40), 0, 0, 0, 0, "clear_after_timeout");
    do_cmd(1, 0, 1, mk_b($urandom), 1, 0, 0, 0, "collision_b_na");
    do_cmd(0, 1, 1, mk_a(1'b0, 8'h55), 0, 0, 0, 0, "collision_a_na");
    do_cmd(0, 0, 1, mk_a(1'b0, 8'h00), 0, 4, $urandom, 3, "drop_in_rd_wait");
    do_cmd(0, 1, 0, mk_a(1'b1, 8'h80), 2, 0, $urandom, 0, "read_same_cycle");

    // Read that times out waiting for data, then the data shows up in IDLE.
    do_cmd(0, 1, 0, mk_a(1'b1, 8'h33), 0, 50, $urandom, 0, "read_timeout");
    @(negedge clk);
    mem_if.mem_readdatavalid = 1'b1;
    mem_if.mem_readdata = 32'hA5A5_5A5A;
    @(negedge clk);
    mem_if.mem_readdatavalid = 1'b0;
    check("late_return_mondreg", MonDReg, exp_mon);
    check("late_return_addr", mem_if.mem_address, exp_addr);
    check("late_return_busy", busy, 1'b0);

    for (int i = 0; i < 12; i++) begin
      int kind;
      kind = $urandom_range(0, 3);
      case (kind)
        0: do_cmd(1, 0, 0, mk_b($urandom), $urandom_range(0, 5), 0, 0, 0, "rand_write");
        1: do_cmd(0, 1, 0, mk_a(1'b1, ADDR_W'($urandom)), $urandom_range(0, 4),
                  $urandom_range(0, 4), $urandom, 0, "rand_read_a");
        2: do_cmd(0, 0, 1, mk_a(1'b0, 8'h00), $urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom, $urandom_range(0, 3), "rand_read_na");
        default: do_cmd(0, 1, 0, mk_a(1'b0, ADDR_W'($urandom)), 0, 0, 0, 0, "rand_load");
      endcase
    end

    // Reset asserted while the read is waiting for data.
    @(negedge clk);
    take_no_action_ocimem_a = 1'b1;
    mem_if.mem_waitrequest = 1'b0;
    @(negedge clk);
    take_no_action_ocimem_a = 1'b0;
    check("midrd_req", mem_if.mem_read, 1'b1);
    @(negedge clk);
    check("midrd_wait_busy", busy, 1'b1);
    #2 reset = 1'b1;
    #1;
    check("midrd_reset_read", mem_if.mem_read, 1'b0);
    check("midrd_reset_busy", busy, 1'b0);
    check("midrd_reset_mondreg", MonDReg, 32'h0);
    check("midrd_reset_flags", {monitor_ready, monitor_error}, 2'b00);
    check("midrd_reset_addr", mem_if.mem_address, '0);
    check("midrd_reset_wdata", mem_if.mem_writedata, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    exp_addr = '0;
    exp_mon = '0;
    exp_wdata = '0;
    @(negedge clk);
    mem_if.mem_readdatavalid = 1'b1;
    mem_if.mem_readdata = 32'hCAFE_F00D;
    @(negedge clk);
    mem_if.mem_readdatavalid = 1'b0;
    check("post_reset_late_mondreg", MonDReg, 32'h0);
    check("post_reset_late_busy", busy, 1'b0);
    check("post_reset_late_ready", monitor_ready, 1'b0);
    do_cmd(1, 0, 0, mk_b($urandom), 0, 0, 0, 0, "post_reset_write");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
